// File: rtl/dt_classifier.sv
// Four-node decision-tree classifier fed by the histogram stage; one node per clock.
// Optional DT_PATH_EN adds a path_taken output recording which nodes were visited.
module dt_classifier #(
   parameter int               BIN_W = 12,
   parameter logic [BIN_W-1:0] T0    = BIN_W'(200),
   parameter logic [BIN_W-1:0] T1    = BIN_W'(150),
   parameter logic [BIN_W-1:0] T2    = BIN_W'(100),
   parameter logic [BIN_W-1:0] T3    = BIN_W'(50)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             done_histogram,
   input  logic [BIN_W-1:0] bin_0,
   input  logic [BIN_W-1:0] bin_34,
   input  logic [BIN_W-1:0] bin_38,
   input  logic [BIN_W-1:0] bin_39,
   input  logic             result_ready,
`ifdef DT_PATH_EN
   output logic [3:0]       path_taken,
`endif
   output logic             class_valid,
   output logic             class_out,
   output logic             busy,
   output logic             overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       node;
   logic             done_d;
   logic [BIN_W-1:0] f0, f34, f38, f39;

   logic             start;
   logic             go_left;
   logic             leaf_hit;
   logic             leaf_val;
   logic [1:0]       next_node;

   assign start = done_histogram & ~done_d;

   // Tree walk uses only the features captured at the start edge.
   always_comb begin
      go_left   = 1'b0;
      leaf_hit  = 1'b0;
      leaf_val  = 1'b0;
      next_node = node;
      unique case (node)
         2'd0: begin
            go_left   = (f0 <= T0);
            next_node = go_left ? 2'd1 : 2'd2;
         end
         2'd1: begin
            go_left   = (f34 <= T1);
            leaf_hit  = go_left;
            leaf_val  = 1'b0;
            next_node = 2'd3;
         end
         2'd2: begin
            go_left   = (f38 <= T2);
            leaf_hit  = ~go_left;
            leaf_val  = 1'b1;
            next_node = 2'd3;
         end
         2'd3: begin
            go_left   = (f39 <= T3);
            leaf_hit  = 1'b1;
            leaf_val  = ~go_left;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         node        <= 2'd0;
         done_d      <= 1'b0;
         f0          <= '0;
         f34         <= '0;
         f38         <= '0;
         f39         <= '0;
         class_valid <= 1'b0;
         class_out   <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         done_d <= done_histogram;
         unique case (state)
            IDLE: begin
               if (start) begin
                  f0    <= bin_0;
                  f34   <= bin_34;
                  f38   <= bin_38;
                  f39   <= bin_39;
                  node  <= 2'd0;
                  state <= EVAL;
                  busy  <= 1'b1;
               end
            end
            EVAL: begin
               if (start)
                  overrun <= 1'b1;
               if (leaf_hit) begin
                  class_out   <= leaf_val;
                  class_valid <= 1'b1;
                  state       <= OUT;
               end else begin
                  node <= next_node;
               end
            end
            OUT: begin
               if (start)
                  overrun <= 1'b1;
               if (result_ready) begin
                  class_valid <= 1'b0;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DT_PATH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         path_taken <= 4'd0;
      end else if (state == IDLE && start) begin
         path_taken <= 4'd0;
      end else if (state == EVAL) begin
         path_taken[node] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dt_classifier.sv
// Directed-vector bench for dt_classifier: tree paths, latency, hold, overrun, reset.
// Build with DT_PATH_EN defined to also check path_taken.
module tb_dt_classifier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        done_histogram;
   logic [11:0] bin_0, bin_34, bin_38, bin_39;
   logic        result_ready;
   logic        class_valid;
   logic        class_out;
   logic        busy;
   logic        overrun;
`ifdef DT_PATH_EN
   logic [3:0]  path_taken;
`endif

   int checks = 0;
   int errors = 0;

   dt_classifier dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .done_histogram (done_histogram),
      .bin_0          (bin_0),
      .bin_34         (bin_34),
      .bin_38         (bin_38),
      .bin_39         (bin_39),
      .result_ready   (result_ready),
`ifdef DT_PATH_EN
      .path_taken     (path_taken),
`endif
      .class_valid    (class_valid),
      .class_out      (class_out),
      .busy           (busy),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Re-arm, present bins, raise done; returns just after edge E0.
   // Bins are then scrambled to show the result depends only on captured values.
   task automatic start_run(input logic [11:0] b0, input logic [11:0] b34,
                            input logic [11:0] b38, input logic [11:0] b39,
                            input logic rdy);
      done_histogram = 1'b0;
      tick;
      tick;
      bin_0  = b0;
      bin_34 = b34;
      bin_38 = b38;
      bin_39 = b39;
      result_ready   = rdy;
      done_histogram = 1'b1;
      tick;
      bin_0  = ~b0;
      bin_34 = ~b34;
      bin_38 = ~b38;
      bin_39 = ~b39;
   endtask

   task automatic expect_result(input string tag, input int lat,
                                input logic cls, input logic [3:0] path);
      repeat (lat - 1) tick;
      chk({tag, "_early_valid"}, 32'(class_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick;
      chk({tag, "_valid"}, 32'(class_valid), 32'd1);
      chk({tag, "_class"}, 32'(class_out), 32'(cls));
`ifdef DT_PATH_EN
      chk({tag, "_path"}, 32'(path_taken), 32'(path));
`else
      if (path > 4'd15) $display("unreachable");
`endif
   endtask

   initial begin
      rst_n          = 1'b0;
      done_histogram = 1'b0;
      result_ready   = 1'b0;
      bin_0  = '0;
      bin_34 = '0;
      bin_38 = '0;
      bin_39 = '0;
      tick;
      tick;
      chk("rst_valid", 32'(class_valid), 32'd0);
      chk("rst_class", 32'(class_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef DT_PATH_EN
      chk("rst_path", 32'(path_taken), 32'd0);
`endif
      rst_n = 1'b1;
      tick;

      // 1: tie on node1 goes left, 2-node path, valid for exactly one cycle
      start_run(12'd100, 12'd150, 12'd0, 12'd0, 1'b1);
      expect_result("t1", 2, 1'b0, 4'b0011);
      tick;
      chk("t1_valid_drop", 32'(class_valid), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);

      // 2: 3-node path via node3, tie then one above
      start_run(12'd100, 12'd151, 12'd0, 12'd50, 1'b1);
      expect_result("t2a", 3, 1'b0, 4'b1011);
      tick;
      start_run(12'd100, 12'd151, 12'd0, 12'd51, 1'b1);
      expect_result("t2b", 3, 1'b1, 4'b1011);
      tick;

      // 3: right at node0, right at node2
      start_run(12'd201, 12'd0, 12'd101, 12'd0, 1'b1);
      expect_result("t3", 2, 1'b1, 4'b0101);
      tick;
      chk("t3_valid_drop", 32'(class_valid), 32'd0);

      // 4: consumer stalls, result held; no second result while done stays high
      start_run(12'd201, 12'd0, 12'd100, 12'd4095, 1'b0);
      expect_result("t4", 3, 1'b1, 4'b1101);
      for (int i = 0; i < 9; i++) begin
         tick;
         chk("t4_hold_valid", 32'(class_valid), 32'd1);
         chk("t4_hold_class", 32'(class_out), 32'd1);
      end
      result_ready = 1'b1;
      tick;
      chk("t4_release", 32'(class_valid), 32'd0);
      chk("t4_class_kept", 32'(class_out), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("t4_no_rerun", 32'(class_valid | busy), 32'd0);
      end

      // 5: done toggles during EVAL -> ignored, overrun sticks
      start_run(12'd100, 12'd151, 12'd0, 12'd51, 1'b1);
      done_histogram = 1'b0;
      tick;
      chk("t5_no_overrun_yet", 32'(overrun), 32'd0);
      done_histogram = 1'b1;
      tick;
      chk("t5_overrun", 32'(overrun), 32'd1);
      tick;
      chk("t5_valid", 32'(class_valid), 32'd1);
      chk("t5_class", 32'(class_out), 32'd1);
      tick;
      chk("t5_valid_drop", 32'(class_valid), 32'd0);
      repeat (3) tick;
      chk("t5_no_rerun", 32'(class_valid | busy), 32'd0);
      chk("t5_overrun_sticky", 32'(overrun), 32'd1);

      // 6: asynchronous reset mid-EVAL
      start_run(12'd201, 12'd0, 12'd101, 12'd0, 1'b1);
      tick;
      chk("t6_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(class_valid), 32'd0);
      chk("t6_class", 32'(class_out), 32'd0);
      chk("t6_busy_rst", 32'(busy), 32'd0);
      chk("t6_overrun", 32'(overrun), 32'd0);
      tick;
      done_histogram = 1'b0;
      rst_n = 1'b1;
      tick;
      chk("t6_idle", 32'(busy), 32'd0);
      start_run(12'd201, 12'd0, 12'd101, 12'd0, 1'b1);
      expect_result("t6_rerun", 2, 1'b1, 4'b0101);
      tick;
      chk("t6_rerun_drop", 32'(class_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
